// File: rtl/cache_fill_if.sv
// Miss-fill bus between the cache stall logic, main memory and the fill FSM.
// master = cache/memory side, slave = fill FSM.
interface cache_fill_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int OFF_W  = 3
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_enable;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [OFF_W-1:0]  cache_word_offset;
  logic [DATA_W-1:0] data_out;
  logic              write_tag_array;
  logic [ADDR_W-1:0] block_address;

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_enable, memory_address, write_data_array,
           cache_word_offset, data_out, write_tag_array, block_address
  );

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_enable, memory_address, write_data_array,
           cache_word_offset, data_out, write_tag_array, block_address
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: stalls the pipeline, streams one block from main
// memory into the data array, then writes the tag to validate the block.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic          clk,
  input  logic          rst,
  cache_fill_if.slave   bus
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rsp_cnt;
  logic [ADDR_W-1:0] blk_addr;
  logic              req_act;
  logic              rsp_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request and response counters run independently so that a new request
  // can issue in the same cycle an earlier one returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      blk_addr <= '0;
    end else if (state_q == IDLE) begin
      if (bus.miss_detected) begin
        blk_addr <= bus.miss_address & BLK_MASK;
        req_cnt  <= '0;
        rsp_cnt  <= '0;
      end
    end else if (state_q == FILL) begin
      if (req_act) req_cnt <= req_cnt + CNT_W'(1);
      if (rsp_act) rsp_cnt <= rsp_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d               = state_q;
    req_act               = 1'b0;
    rsp_act               = 1'b0;
    bus.fsm_busy          = 1'b0;
    bus.mem_enable        = 1'b0;
    bus.memory_address    = '0;
    bus.write_data_array  = 1'b0;
    bus.cache_word_offset = '0;
    bus.data_out          = '0;
    bus.write_tag_array   = 1'b0;
    bus.block_address     = blk_addr;

    case (state_q)
      IDLE: begin
        // Stall in the miss cycle itself so the pipeline never moves past it.
        bus.fsm_busy = bus.miss_detected;
        if (bus.miss_detected) state_d = FILL;
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        req_act      = (req_cnt < CNT_FULL);
        rsp_act      = bus.memory_data_valid && (rsp_cnt < CNT_FULL);
        if (req_act) begin
          bus.mem_enable     = 1'b1;
          bus.memory_address = blk_addr + ADDR_W'({req_cnt, 1'b0});
        end
        if (rsp_act) begin
          bus.write_data_array  = 1'b1;
          bus.cache_word_offset = rsp_cnt[OFF_W-1:0];
          bus.data_out          = bus.memory_data;
          if (rsp_cnt == CNT_LAST) state_d = TAG;
        end
      end
      TAG: begin
        bus.fsm_busy        = 1'b1;
        bus.write_tag_array = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a latency-configurable memory model.
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_fill_if #(.ADDR_W(16), .DATA_W(16), .OFF_W(3)) bus ();

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] addr;
    int          rdy;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_seen = 0;
  int          tag_seen = 0;
  logic [15:0] exp_req_q[$];
  logic [18:0] exp_wr_q[$];
  logic [15:0] exp_tag_q[$];
  req_t        mem_q[$];
  req_t        resp_r;
  int          lat = 4;
  bit          gap_mode = 1'b0;
  bit          gap_tog = 1'b0;
  int          extra_valids = 0;
  int          extra_left = 0;
  logic [15:0] dbase = 16'hA000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.mem_enable === 1'b1) begin
      if (exp_req_q.size() == 0) unexpected("unexpected_req", bus.memory_address);
      else chk("mem_addr", bus.memory_address, exp_req_q.pop_front());
    end
    if (bus.write_data_array === 1'b1) begin
      wr_seen++;
      if (exp_wr_q.size() == 0) unexpected("unexpected_write", {bus.cache_word_offset, bus.data_out});
      else chk("write_off_data", {bus.cache_word_offset, bus.data_out}, exp_wr_q.pop_front());
    end
    if (bus.write_tag_array === 1'b1) begin
      tag_seen++;
      if (exp_tag_q.size() == 0) unexpected("unexpected_tag", bus.block_address);
      else chk("tag_block", bus.block_address, exp_tag_q.pop_front());
    end
  end

  // Memory model: record requests, answer in order after lat-1 cycles
  always @(negedge clk) begin
    if (bus.mem_enable === 1'b1 && !rst)
      mem_q.push_back(req_t'{bus.memory_address, cyc + lat - 1});
  end

  always @(posedge clk) begin
    #1;
    gap_tog = ~gap_tog;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'h0000;
    if (rst) begin
      mem_q.delete();
      extra_left = 0;
    end else if (mem_q.size() > 0) begin
      if (mem_q[0].rdy <= cyc && (!gap_mode || gap_tog)) begin
        resp_r = mem_q.pop_front();
        bus.memory_data_valid = 1'b1;
        bus.memory_data = dbase + 16'(resp_r.addr[3:1]);
        if (mem_q.size() == 0) extra_left = extra_valids;
      end
    end else if (extra_left > 0) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data = 16'hDEAD;
      extra_left--;
    end
  end

  task automatic check_idle(input string name);
    chk(name, {bus.fsm_busy, bus.mem_enable, bus.write_data_array, bus.write_tag_array,
               bus.memory_address, bus.cache_word_offset, bus.data_out}, 64'd0);
  endtask

  task automatic push_expect(input logic [15:0] miss);
    logic [15:0] base;
    base = miss & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      exp_req_q.push_back(base + 16'(2 * i));
      exp_wr_q.push_back({3'(i), dbase + 16'(i)});
    end
    exp_tag_q.push_back(base);
  endtask

  task automatic start_miss(input logic [15:0] miss);
    @(posedge clk); #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = miss;
    @(negedge clk);
    chk("busy_in_miss_cycle", bus.fsm_busy, 1);
    @(posedge clk); #1;
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;
  endtask

  task automatic do_fill(input logic [15:0] miss, input logic [15:0] d0, input int l,
                         input bit gap, input int extra, input bit inject);
    int  busy_cnt;
    int  t0;
    bit  done;
    logic [15:0] base;
    base = miss & 16'hFFF0;
    lat = l; gap_mode = gap; extra_valids = extra; dbase = d0;
    t0 = tag_seen;
    push_expect(miss);
    start_miss(miss);
    busy_cnt = 1;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.fsm_busy === 1'b1) busy_cnt++;
      else done = 1'b1;
      if (inject && k == 2) begin
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h4000;
      end
      if (inject && k == 3) begin
        bus.miss_detected = 1'b0;
        bus.miss_address  = 16'h0000;
      end
      if (inject && k == 5) chk("block_addr_hold", bus.block_address, base);
    end
    if (!done) unexpected("busy_timeout", busy_cnt);
    if (!gap) chk("busy_cycles", busy_cnt, 1 + (l - 1 + 8) + 1);
    chk("tag_once", tag_seen - t0, 1);
    chk("fill_drained", exp_req_q.size() + exp_wr_q.size() + exp_tag_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle("idle_after_fill");
    end
    extra_valids = 0;
  endtask

  initial begin
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'h0000;

    // Reset mid-cycle, then quiet idle
    #3 rst = 1'b1;
    @(negedge clk);
    check_idle("reset_outputs");
    chk("reset_block_addr", bus.block_address, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_idle("idle_quiet");
      chk("idle_block_addr", bus.block_address, 0);
    end

    // Directed single fill with a miss injected while busy
    do_fill(16'h1236, 16'hA000, 4, 1'b0, 0, 1'b1);
    // Gapped responses followed by surplus valids
    do_fill(16'h2468, 16'h5A00, 3, 1'b1, 3, 1'b0);
    // Top-of-memory block
    do_fill(16'hFFFA, 16'h7770, 4, 1'b0, 0, 1'b0);

    // Reset after the third response
    begin
      int w0;
      int t0;
      bit hit;
      lat = 3; gap_mode = 1'b0; dbase = 16'h3300;
      w0 = wr_seen; t0 = tag_seen; hit = 1'b0;
      push_expect(16'h0150);
      start_miss(16'h0150);
      for (int k = 0; k < 50 && !hit; k++) begin
        @(negedge clk); #1;
        if (wr_seen >= w0 + 3) hit = 1'b1;
      end
      if (!hit) unexpected("third_resp_timeout", wr_seen - w0);
      @(posedge clk); #2;
      rst = 1'b1;
      exp_req_q.delete(); exp_wr_q.delete(); exp_tag_q.delete();
      @(negedge clk);
      check_idle("reset_mid_fill");
      chk("reset_mid_block_addr", bus.block_address, 0);
      @(posedge clk); #3 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_idle("idle_after_abort");
      end
      chk("no_tag_after_abort", tag_seen - t0, 0);
    end
    do_fill(16'h0020, 16'hC000, 4, 1'b0, 0, 1'b0);

    // Randomised fills
    for (int n = 0; n < 8; n++) begin
      do_fill(16'($urandom), 16'($urandom), int'($urandom_range(2, 6)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling responder behind the CPU's cache stall interface.
- When a cache lookup misses, it stalls the requesting pipeline stage via fsm_busy and fetches the whole 16-byte block (8 words) from multi-cycle main memory.
- Each returned word is written into the cache data array. The tag is written last, then the block releases the stall.
- One instance serves the I-cache and one serves the D-cache. fsm_busy drives IFStall or MEMStall respectively.

Parameters:
- WORDS_PER_BLOCK, 8, words fetched per fill; must be a power of two.
- ADDR_W, 16, byte-address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- miss_detected  input  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  input  16  byte address of the missing access; sampled with miss_detected.
- memory_data_valid  input  1  main memory returns one word this cycle.
- memory_data  input  16  word returned by main memory.
- fsm_busy  output  1  stall to the pipeline; high while a fill is in progress.
- mem_enable  output  1  read request strobe to main memory.
- memory_address  output  16  byte address of the current read request.
- write_data_array  output  1  write data_out into the cache data array at cache_word_offset.
- cache_word_offset  output  3  word index within the block for the data-array write.
- data_out  output  16  word to write into the data array.
- write_tag_array  output  1  single-cycle strobe: write the tag and set the valid bit for the block.
- block_address  output  16  base of the block being filled, low 4 bits zero; used by the cache for index and tag.

Behaviour:
- States: IDLE, FILL, TAG.
- Reset (asynchronous, any state): state=IDLE; req_cnt=0; rsp_cnt=0; block_address=0.
  - All strobes are 0 and memory_address=0 while in IDLE.
  - Reset during FILL or TAG abandons the fill. No tag write occurs, so the partially filled block stays invalid.
- fsm_busy is combinational: (state!=IDLE) | (state==IDLE & miss_detected). The stall is therefore asserted in the same cycle as the miss.
- IDLE:
  - On miss_detected=1: latch block_address = miss_address & 16'hFFF0, clear both counters, go to FILL next edge.
  - memory_data_valid is ignored in IDLE.
- FILL, request side:
  - While req_cnt < WORDS_PER_BLOCK: mem_enable=1, memory_address = block_address + 2*req_cnt, req_cnt increments every cycle.
  - This gives exactly 8 back-to-back requests starting in the first FILL cycle. mem_enable=0 once req_cnt reaches 8.
- FILL, response side:
  - Each cycle with memory_data_valid=1: write_data_array=1, cache_word_offset=rsp_cnt[2:0], data_out=memory_data, rsp_cnt increments.
  - write_data_array is combinational on memory_data_valid & state==FILL & rsp_cnt<8.
  - Responses arrive in request order.
  - Requests and responses may overlap in the same cycle; the counters are independent.
- FILL -> TAG: on the edge where a valid response is accepted with rsp_cnt==7.
- TAG:
  - One cycle with write_tag_array=1 and fsm_busy=1.
  - Go to IDLE next edge. The stalled access retries and hits in the following cycle.
- Ignored inputs:
  - miss_detected while state!=IDLE is ignored; no nesting or queueing.
  - memory_data_valid in TAG, or beyond the 8th response, is ignored.
- Arithmetic: memory_address wraps modulo 2^16. A block at 16'hFFF0 issues requests 16'hFFF0 through 16'hFFFE with no carry out.
- Latency: with main-memory latency L cycles (request at cycle t, valid at t+L-1):
  - fsm_busy is high for 1 (miss cycle) + (L-1+8) (FILL) + 1 (TAG) cycles.
  - For L=4 that is 13 cycles.

Test Plan:
- Reset then idle: rst=1 mid-cycle, release, miss_detected=0 for 10 cycles -> every output 0, fsm_busy=0.
- Single fill, L=4, miss_address=16'h1236:
  - fsm_busy=1 in the miss cycle.
  - memory_address 16'h1230, 1232 ... 123E on FILL cycles 1-8 with mem_enable=1.
  - Data 16'hA000+i returned on FILL cycles 4-11 -> write_data_array with offsets 0-7 and matching data_out.
  - write_tag_array=1 for exactly one cycle with block_address=16'h1230; fsm_busy falls after 13 total cycles.
- Miss during busy: assert miss_detected with miss_address=16'h4000 during FILL -> ignored; block_address stays 16'h1230.
- Gapped responses: valid pulsed every other cycle -> 8 writes with offsets 0-7 in order. The TAG strobe follows the 8th valid only; extra valids after it produce no write.
- Wrap-around: miss_address=16'hFFFA -> requests 16'hFFF0 through 16'hFFFE and no address above 16'hFFFE.
- Reset mid-fill: rst after the 3rd response -> immediate IDLE, write_tag_array never pulses. A new miss at 16'h0020 then runs a clean fill starting at offset 0.
